// File: rtl/can_fc_pkg.sv
// Shared types, widths and helpers for the CAN fault-confinement block.
package can_fc_pkg;

  typedef enum logic [1:0] {
    FC_ERR_ACTIVE,
    FC_ERR_PASSIVE,
    FC_BUS_OFF_WAIT,
    FC_BUS_OFF_RECOVER
  } fc_state_t;

  localparam int unsigned TEC_BUS_OFF = 256;
  localparam int unsigned REC_MAX     = 255;

  localparam int unsigned TEC_W      = 9;
  localparam int unsigned TEC_CALC_W = 10;
  localparam int unsigned REC_W      = 8;
  localparam int unsigned REC_SUM_W  = REC_W + 1;
  localparam int unsigned EWL_W      = 8;
  localparam int unsigned RUN_W      = 4;
  localparam int unsigned SEQ_W      = 8;

  // Saturating REC increment.
  function automatic logic [REC_W-1:0] rec_add_sat(input logic [REC_W-1:0] r,
                                                   input logic [REC_W-1:0] inc);
    logic [REC_SUM_W-1:0] sum;
    sum = {1'b0, r} + {1'b0, inc};
    if (sum > REC_SUM_W'(REC_MAX)) return REC_W'(REC_MAX);
    return sum[REC_W-1:0];
  endfunction

endpackage

// File: rtl/can_fault_confinement_if.sv
// Event, CPU-write and status signals between the protocol/register side and fault confinement.
interface can_fault_confinement_if;
  import can_fc_pkg::*;

  logic             sample_point_i;
  logic             sampled_bit_i;
  logic             reset_mode_i;
  logic             rx_err_i;
  logic             rx_err_primary_i;
  logic             tx_err_i;
  logic             rx_ok_i;
  logic             tx_ok_i;
  logic [EWL_W-1:0] ewl_i;
  logic             tec_wr_i;
  logic             rec_wr_i;
  logic [REC_W-1:0] wr_data_i;

  logic [TEC_W-1:0] tec_o;
  logic [REC_W-1:0] rec_o;
  logic             error_passive_o;
  logic             node_bus_off_o;
  logic             err_warning_o;
  logic             bus_off_pulse_o;
  logic             set_reset_mode_o;
  logic             recovered_pulse_o;

  modport master (
    output sample_point_i, sampled_bit_i, reset_mode_i, rx_err_i, rx_err_primary_i,
           tx_err_i, rx_ok_i, tx_ok_i, ewl_i, tec_wr_i, rec_wr_i, wr_data_i,
    input  tec_o, rec_o, error_passive_o, node_bus_off_o, err_warning_o,
           bus_off_pulse_o, set_reset_mode_o, recovered_pulse_o
  );

  modport slave (
    input  sample_point_i, sampled_bit_i, reset_mode_i, rx_err_i, rx_err_primary_i,
           tx_err_i, rx_ok_i, tx_ok_i, ewl_i, tec_wr_i, rec_wr_i, wr_data_i,
    output tec_o, rec_o, error_passive_o, node_bus_off_o, err_warning_o,
           bus_off_pulse_o, set_reset_mode_o, recovered_pulse_o
  );
endinterface

// File: rtl/can_bus_off_recovery_cnt.sv
// Counts runs of recessive sample points and completed runs for bus-off recovery.
module can_bus_off_recovery_cnt
  import can_fc_pkg::*;
#(
  parameter int unsigned RECESSIVE_RUN = 11,
  parameter int unsigned RECOVERY_SEQ  = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable,
  input  logic             clear,
  input  logic             sample_point_i,
  input  logic             sampled_bit_i,
  output logic             done_c,
  output logic [SEQ_W-1:0] seq_cnt
);

  logic [RUN_W-1:0] run_q;
  logic [SEQ_W-1:0] seq_q;
  logic             run_end_c;

  assign run_end_c = enable && !clear && sample_point_i && sampled_bit_i &&
                     (run_q == RUN_W'(RECESSIVE_RUN - 1));
  // Completion is flagged on the sample that finishes the last run.
  assign done_c    = run_end_c && (seq_q == SEQ_W'(RECOVERY_SEQ - 1));
  assign seq_cnt   = seq_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q <= '0;
      seq_q <= '0;
    end else if (clear) begin
      run_q <= '0;
      seq_q <= '0;
    end else if (enable && sample_point_i) begin
      if (!sampled_bit_i) begin
        run_q <= '0;
      end else if (run_end_c) begin
        run_q <= '0;
        seq_q <= done_c ? '0 : seq_q + SEQ_W'(1);
      end else begin
        run_q <= run_q + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/can_fault_confinement.sv
// CAN TEC/REC fault confinement: error-active/passive/bus-off sequencing and bus-off recovery.
module can_fault_confinement
  import can_fc_pkg::*;
#(
  parameter int unsigned PASSIVE_LIM   = 128,
  parameter int unsigned REC_OK_RELOAD = 120,
  parameter int unsigned RECESSIVE_RUN = 11,
  parameter int unsigned RECOVERY_SEQ  = 128
) (
  input logic                    clk_i,
  input logic                    rst_i,
  can_fault_confinement_if.slave bus
);

  fc_state_t             state_q, state_nxt;
  logic [TEC_W-1:0]      tec_q, tec_d;
  logic [REC_W-1:0]      rec_q, rec_d;
  logic [TEC_CALC_W-1:0] tec_nxt;
  logic [REC_W-1:0]      rec_nxt;
  logic                  reset_mode_q;
  logic                  passive_q, bus_off_q, bus_off_pulse_q, recovered_q;
  logic                  bus_off_p, recovered_p;
  logic                  ev_en, wr_en, tec_wr_ff;
  logic                  rcv_en, rcv_clr, rcv_done;
  logic [SEQ_W-1:0]      seq_cnt;

  can_bus_off_recovery_cnt #(
    .RECESSIVE_RUN (RECESSIVE_RUN),
    .RECOVERY_SEQ  (RECOVERY_SEQ)
  ) u_recovery (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable         (rcv_en),
    .clear          (rcv_clr),
    .sample_point_i (bus.sample_point_i),
    .sampled_bit_i  (bus.sampled_bit_i),
    .done_c         (rcv_done),
    .seq_cnt        (seq_cnt)
  );

  assign rcv_clr = (state_q != FC_BUS_OFF_RECOVER);
  assign rcv_en  = !bus.reset_mode_i;

  // Next counter values from this cycle's strobes; writes override events.
  always_comb begin
    ev_en     = !bus.reset_mode_i && ((state_q == FC_ERR_ACTIVE) || (state_q == FC_ERR_PASSIVE));
    wr_en     = bus.reset_mode_i;
    tec_wr_ff = wr_en && bus.tec_wr_i && (bus.wr_data_i == 8'hFF);

    rec_nxt = rec_q;
    if (wr_en && bus.rec_wr_i) begin
      rec_nxt = bus.wr_data_i;
    end else if (ev_en) begin
      if (bus.rx_err_primary_i)    rec_nxt = rec_add_sat(rec_q, REC_W'(8));
      else if (bus.rx_err_i)       rec_nxt = rec_add_sat(rec_q, REC_W'(1));
      else if (bus.rx_ok_i) begin
        if (rec_q >= REC_W'(PASSIVE_LIM)) rec_nxt = REC_W'(REC_OK_RELOAD);
        else if (rec_q != '0)             rec_nxt = rec_q - REC_W'(1);
      end
    end

    tec_nxt = {1'b0, tec_q};
    if (wr_en && bus.tec_wr_i) begin
      tec_nxt = TEC_CALC_W'(bus.wr_data_i);
    end else if (ev_en) begin
      if (bus.tx_err_i)                 tec_nxt = {1'b0, tec_q} + TEC_CALC_W'(8);
      else if (bus.tx_ok_i && tec_q != '0) tec_nxt = {1'b0, tec_q} - TEC_CALC_W'(1);
    end
  end

  // Next-state and registered-output decisions.
  always_comb begin
    state_nxt   = state_q;
    tec_d       = tec_nxt[TEC_W-1:0];
    rec_d       = rec_nxt;
    bus_off_p   = 1'b0;
    recovered_p = 1'b0;
    unique case (state_q)
      FC_ERR_ACTIVE, FC_ERR_PASSIVE: begin
        if ((tec_nxt >= TEC_CALC_W'(TEC_BUS_OFF)) || tec_wr_ff) begin
          state_nxt = FC_BUS_OFF_WAIT;
          bus_off_p = 1'b1;
          rec_d     = '0;
          if (tec_nxt >= TEC_CALC_W'(TEC_BUS_OFF)) tec_d = TEC_W'(TEC_BUS_OFF);
        end else if ((tec_nxt >= TEC_CALC_W'(PASSIVE_LIM)) || (rec_nxt >= REC_W'(PASSIVE_LIM))) begin
          state_nxt = FC_ERR_PASSIVE;
        end else begin
          state_nxt = FC_ERR_ACTIVE;
        end
      end
      FC_BUS_OFF_WAIT: begin
        if (reset_mode_q && !bus.reset_mode_i) state_nxt = FC_BUS_OFF_RECOVER;
      end
      FC_BUS_OFF_RECOVER: begin
        if (bus.reset_mode_i) begin
          state_nxt = FC_BUS_OFF_WAIT;
        end else if (rcv_done) begin
          state_nxt   = FC_ERR_ACTIVE;
          tec_d       = '0;
          rec_d       = '0;
          recovered_p = 1'b1;
        end
      end
      default: state_nxt = FC_ERR_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= FC_ERR_ACTIVE;
      tec_q           <= '0;
      rec_q           <= '0;
      reset_mode_q    <= 1'b0;
      passive_q       <= 1'b0;
      bus_off_q       <= 1'b0;
      bus_off_pulse_q <= 1'b0;
      recovered_q     <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      tec_q           <= tec_d;
      rec_q           <= rec_d;
      reset_mode_q    <= bus.reset_mode_i;
      passive_q       <= (state_nxt == FC_ERR_PASSIVE);
      bus_off_q       <= (state_nxt == FC_BUS_OFF_WAIT) || (state_nxt == FC_BUS_OFF_RECOVER);
      bus_off_pulse_q <= bus_off_p;
      recovered_q     <= recovered_p;
    end
  end

  // During recovery REC reports the number of completed recessive runs.
  assign bus.rec_o             = (state_q == FC_BUS_OFF_RECOVER) ? seq_cnt : rec_q;
  assign bus.tec_o             = tec_q;
  assign bus.error_passive_o   = passive_q;
  assign bus.node_bus_off_o    = bus_off_q;
  assign bus.bus_off_pulse_o   = bus_off_pulse_q;
  assign bus.set_reset_mode_o  = bus_off_pulse_q;
  assign bus.recovered_pulse_o = recovered_q;
  assign bus.err_warning_o     = (tec_q >= TEC_W'(bus.ewl_i)) || (rec_q >= bus.ewl_i);

endmodule

// File: tb/tb_can_fault_confinement.sv
// Directed self-checking bench for can_fault_confinement.
module tb_can_fault_confinement;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  can_fault_confinement_if fc_if ();

  can_fault_confinement dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (fc_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    fc_if.sample_point_i   = 1'b0;
    fc_if.sampled_bit_i    = 1'b1;
    fc_if.reset_mode_i     = 1'b0;
    fc_if.rx_err_i         = 1'b0;
    fc_if.rx_err_primary_i = 1'b0;
    fc_if.tx_err_i         = 1'b0;
    fc_if.rx_ok_i          = 1'b0;
    fc_if.tx_ok_i          = 1'b0;
    fc_if.ewl_i            = 8'd96;
    fc_if.tec_wr_i         = 1'b0;
    fc_if.rec_wr_i         = 1'b0;
    fc_if.wr_data_i        = 8'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic tx_err(input int n);
    for (int i = 0; i < n; i++) begin
      fc_if.tx_err_i = 1'b1;
      step();
    end
    fc_if.tx_err_i = 1'b0;
  endtask

  task automatic rx_err(input int n);
    for (int i = 0; i < n; i++) begin
      fc_if.rx_err_i = 1'b1;
      step();
    end
    fc_if.rx_err_i = 1'b0;
  endtask

  task automatic write_rec(input logic [7:0] v);
    fc_if.reset_mode_i = 1'b1;
    fc_if.rec_wr_i     = 1'b1;
    fc_if.wr_data_i    = v;
    step();
    fc_if.rec_wr_i     = 1'b0;
    fc_if.reset_mode_i = 1'b0;
    step();
  endtask

  task automatic sample(input logic b);
    fc_if.sample_point_i = 1'b1;
    fc_if.sampled_bit_i  = b;
    step();
    fc_if.sample_point_i = 1'b0;
    fc_if.sampled_bit_i  = 1'b1;
  endtask

  initial begin
    logic early;
    idle_inputs();
    step();
    chk("rst_tec", fc_if.tec_o, 0);
    chk("rst_rec", fc_if.rec_o, 0);
    chk("rst_passive", fc_if.error_passive_o, 0);
    chk("rst_busoff", fc_if.node_bus_off_o, 0);
    chk("rst_pulse", fc_if.bus_off_pulse_o, 0);
    do_reset();

    // Error-passive threshold on TEC
    tx_err(15);
    chk("tec_120", fc_if.tec_o, 120);
    chk("passive_at_120", fc_if.error_passive_o, 0);
    tx_err(1);
    chk("tec_128", fc_if.tec_o, 128);
    chk("passive_at_128", fc_if.error_passive_o, 1);
    fc_if.tx_ok_i = 1'b1; step(); fc_if.tx_ok_i = 1'b0;
    chk("tec_127", fc_if.tec_o, 127);
    chk("active_at_127", fc_if.error_passive_o, 0);

    // Bus-off entry
    do_reset();
    rx_err(5);
    chk("rec_5", fc_if.rec_o, 5);
    tx_err(31);
    chk("tec_248", fc_if.tec_o, 248);
    chk("busoff_248", fc_if.node_bus_off_o, 0);
    tx_err(1);
    chk("tec_256", fc_if.tec_o, 256);
    chk("busoff_set", fc_if.node_bus_off_o, 1);
    chk("busoff_pulse", fc_if.bus_off_pulse_o, 1);
    chk("set_rm_pulse", fc_if.set_reset_mode_o, 1);
    chk("busoff_rec_clr", fc_if.rec_o, 0);
    chk("busoff_passive", fc_if.error_passive_o, 0);
    fc_if.tx_ok_i = 1'b1; step(); fc_if.tx_ok_i = 1'b0;
    chk("busoff_pulse_end", fc_if.bus_off_pulse_o, 0);
    chk("set_rm_end", fc_if.set_reset_mode_o, 0);
    chk("tec_hold_256", fc_if.tec_o, 256);

    // Recovery with one dominant sample at bit 10 of the first run
    fc_if.reset_mode_i = 1'b1; step();
    fc_if.reset_mode_i = 1'b0; step();
    for (int i = 0; i < 9; i++) sample(1'b1);
    sample(1'b0);
    chk("rcv_seq_0", fc_if.rec_o, 0);
    early = 1'b0;
    for (int i = 1; i <= 1408; i++) begin
      sample(1'b1);
      if (i == 11) chk("rcv_seq_1", fc_if.rec_o, 1);
      if (i == 1397) chk("rcv_seq_127", fc_if.rec_o, 127);
      if (i < 1408 && fc_if.recovered_pulse_o) early = 1'b1;
    end
    chk("rcv_early", early, 0);
    chk("rcv_pulse", fc_if.recovered_pulse_o, 1);
    chk("rcv_tec", fc_if.tec_o, 0);
    chk("rcv_rec", fc_if.rec_o, 0);
    chk("rcv_busoff", fc_if.node_bus_off_o, 0);
    step();
    chk("rcv_pulse_end", fc_if.recovered_pulse_o, 0);

    // REC reload and saturation
    do_reset();
    write_rec(8'd130);
    chk("rec_130", fc_if.rec_o, 130);
    chk("passive_rec", fc_if.error_passive_o, 1);
    fc_if.rx_ok_i = 1'b1; step(); fc_if.rx_ok_i = 1'b0;
    chk("rec_reload", fc_if.rec_o, 120);
    chk("active_reload", fc_if.error_passive_o, 0);
    write_rec(8'd250);
    fc_if.rx_err_i = 1'b1; fc_if.rx_err_primary_i = 1'b1;
    step();
    chk("rec_sat", fc_if.rec_o, 255);
    step();
    fc_if.rx_err_i = 1'b0; fc_if.rx_err_primary_i = 1'b0;
    chk("rec_sat_hold", fc_if.rec_o, 255);
    write_rec(8'd10);
    fc_if.rx_err_i = 1'b1; fc_if.rx_err_primary_i = 1'b1;
    step();
    fc_if.rx_err_i = 1'b0; fc_if.rx_err_primary_i = 1'b0;
    chk("rec_both_plus8", fc_if.rec_o, 18);
    fc_if.rx_ok_i = 1'b1; fc_if.rx_err_i = 1'b1; step();
    fc_if.rx_ok_i = 1'b0; fc_if.rx_err_i = 1'b0;
    chk("rec_err_wins", fc_if.rec_o, 19);

    // Error warning limit
    do_reset();
    rx_err(95);
    chk("warn_95", fc_if.err_warning_o, 0);
    rx_err(1);
    chk("rec_96", fc_if.rec_o, 96);
    chk("warn_96", fc_if.err_warning_o, 1);
    fc_if.rx_ok_i = 1'b1; step(); fc_if.rx_ok_i = 1'b0;
    chk("rec_95", fc_if.rec_o, 95);
    chk("warn_clr", fc_if.err_warning_o, 0);

    // CPU write of TEC=255 forces bus-off; events ignored in reset mode
    do_reset();
    fc_if.reset_mode_i = 1'b1;
    fc_if.tec_wr_i     = 1'b1;
    fc_if.wr_data_i    = 8'd255;
    step();
    fc_if.tec_wr_i     = 1'b0;
    chk("wr_tec", fc_if.tec_o, 255);
    chk("wr_busoff", fc_if.node_bus_off_o, 1);
    tx_err(1);
    chk("rm_tx_ignored", fc_if.tec_o, 255);

    // Asynchronous reset mid-operation
    do_reset();
    rx_err(3);
    tx_err(16);
    chk("pre_arst_passive", fc_if.error_passive_o, 1);
    rst_i = 1'b1;
    #2;
    chk("arst_tec", fc_if.tec_o, 0);
    chk("arst_rec", fc_if.rec_o, 0);
    chk("arst_passive", fc_if.error_passive_o, 0);
    chk("arst_pulse", fc_if.bus_off_pulse_o, 0);
    rst_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
